mult_sequence_controller: RTL and testbench
===========================================

Name: mult_sequence_controller

Overview:
- Control FSM for the sequential signed (sign-magnitude) multiplier datapath.
- Sequences one multiplication: load operands and the sign flag, run WIDTH-1 add/shift iterations over the magnitude bits, apply conditional two's-complement negation, then present the result with a done/ack handshake.
- Sits between the top-level start/ack interface and the datapath registers.
- Its load_Initial output drives the load strobe of the sign-flag register.

Parameters:
- WIDTH, 8: operand width including the sign bit; iterations = WIDTH-1.
- CNT_W, 4: step counter width; must satisfy 2^CNT_W > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiplication; sampled in IDLE and DONE only
- resultAck  input  1  consumer has taken the product; sampled in DONE only
- multiplierLsb  input  1  current LSB of the datapath's shifting multiplier register
- negativeProductFlag  input  1  registered sign of the product from the sign-flag register
- load_Initial  output  1  load operands, clear the accumulator, capture the sign flag
- addEnable  output  1  add the multiplicand magnitude into the accumulator this cycle
- shiftEnable  output  1  shift the accumulator/multiplier pair right by one this cycle
- negateEnable  output  1  replace the product with its two's complement this cycle
- busy  output  1  operation in progress (LOAD, ITER or SIGN)
- done  output  1  product valid and held stable
- stepCount  output  CNT_W  iterations completed in the current operation

Behaviour:
- Clock and reset:
  - Single clock domain. One registered state plus the stepCount register.
  - All strobes are Moore decodes of the registered state, except addEnable = (state==ITER) & multiplierLsb.
- Reset (asynchronous, active-high):
  - state=IDLE, stepCount=0.
  - Every output is 0 while reset is high and after release.
  - Reset mid-operation abandons the operation immediately; no done is produced.
- States:
  - IDLE: all strobes 0. If start=1, go to LOAD.
  - LOAD (1 cycle): load_Initial=1, busy=1, stepCount<=0. Go to ITER.
  - ITER: busy=1, shiftEnable=1, addEnable=multiplierLsb. stepCount<=stepCount+1. When stepCount==WIDTH-2, this is the last iteration; go to SIGN.
  - SIGN (1 cycle): busy=1, negateEnable=negativeProductFlag. Go to DONE.
  - DONE: done=1, busy=0. stepCount holds at WIDTH-1.
    - resultAck=1 and start=0: go to IDLE.
    - start=1, with or without resultAck: go to LOAD. Start counts as an implicit ack and back-to-back operation is supported.
    - Neither asserted: remain in DONE with done held high.
- Timing and latency:
  - Start sampled high at edge N gives load_Initial in cycle N+1 and ITER in cycles N+2 .. N+WIDTH.
  - SIGN occurs at cycle N+WIDTH+1; done first appears at cycle N+WIDTH+2.
  - Start-to-done latency is WIDTH+2 cycles.
- Start handling:
  - start during LOAD, ITER or SIGN is ignored, not queued.
  - start is level-sampled: held high in IDLE it triggers exactly one operation per entry to IDLE/DONE.
- Datapath contract:
  - addEnable and shiftEnable are asserted together in ITER; the datapath performs add-then-shift in one cycle.
  - The multiplier sign bit is never iterated.
- Mutual exclusion and stepCount:
  - load_Initial, shiftEnable, negateEnable and done are mutually exclusive in every cycle.
  - stepCount never exceeds WIDTH-1 and never wraps.

Test Plan:
1. Reset: assert reset asynchronously mid-clock, start=1. Required: all outputs 0 immediately and stepCount=0. After release, start=1 gives load_Initial exactly one cycle later.
2. Nominal sequence, WIDTH=8, start pulsed at edge 0, multiplierLsb pattern 1,0,1,1,0,0,1 on cycles 2..8, negativeProductFlag=0. Required:
   - load_Initial=1 in cycle 1.
   - shiftEnable=1 in cycles 2..8 (7 cycles); addEnable=1 in cycles 2,4,5,8.
   - negateEnable=0 in cycle 9.
   - done=1 from cycle 10 and held until resultAck; stepCount=7.
3. Negative product: same as scenario 2 but negativeProductFlag=1. Required: negateEnable=1 for exactly cycle 9 and no other cycle.
4. Ignored start: pulse start during ITER (cycle 5) and during SIGN. Required: the sequence is unchanged, with exactly one done and no second load_Initial.
5. Back-to-back: in DONE, assert start=1 and resultAck=1 together. Required: done drops and load_Initial=1 the next cycle. With resultAck alone, return to IDLE with done=0 the next cycle.
6. Abort: assert reset in cycle 6 (mid-ITER). Required: busy=0 and no strobes at once; after release the FSM sits in IDLE, and a new start completes in 10 cycles.

Source files
------------

// File: rtl/mult_sequence_controller.sv
// Control FSM for the sequential sign-magnitude multiplier: load, WIDTH-1 add/shift
// iterations, conditional negation, then a done/ack handshake with back-to-back support.
module mult_sequence_controller #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resultAck,
    input  logic             multiplierLsb,
    input  logic             negativeProductFlag,
    output logic             load_Initial,
    output logic             addEnable,
    output logic             shiftEnable,
    output logic             negateEnable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stepCount
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIter,
        StSign,
        StDone
    } stateT;

    localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 2);

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] stepCountQ, stepCountD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ     <= StIdle;
            stepCountQ <= '0;
        end else begin
            stateQ     <= stateD;
            stepCountQ <= stepCountD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:  if (start) stateD = StLoad;
            StLoad:  stateD = StIter;
            StIter:  if (stepCountQ == LastStep) stateD = StSign;
            StSign:  stateD = StDone;
            StDone: begin
                // start doubles as an implicit ack for back-to-back operation
                if (start) begin
                    stateD = StLoad;
                end else if (resultAck) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Cleared on entry to LOAD so the count reads 0 throughout the load cycle.
    always_comb begin
        stepCountD = stepCountQ;
        if (stateD == StLoad) begin
            stepCountD = '0;
        end else if (stateQ == StIter) begin
            stepCountD = stepCountQ + CNT_W'(1);
        end
    end

    always_comb begin
        load_Initial = 1'b0;
        addEnable    = 1'b0;
        shiftEnable  = 1'b0;
        negateEnable = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (stateQ)
            StLoad: begin
                load_Initial = 1'b1;
                busy         = 1'b1;
            end
            StIter: begin
                addEnable   = multiplierLsb;
                shiftEnable = 1'b1;
                busy        = 1'b1;
            end
            StSign: begin
                negateEnable = negativeProductFlag;
                busy         = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign stepCount = stepCountQ;

endmodule

// File: tb/tb_mult_sequence_controller.sv
// Directed bench for mult_sequence_controller: expected per-cycle output vectors are queued
// as stimulus is driven and compared against the DUT when sampled on the falling edge.
module tb_mult_sequence_controller;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [9:0] Full  = 10'h3FF;
    localparam logic [9:0] NoCnt = 10'h3F0;

    typedef struct packed {
        logic [9:0] e;
        logic [9:0] m;
    } expT;

    logic             clk;
    logic             reset;
    logic             start;
    logic             resultAck;
    logic             multiplierLsb;
    logic             negativeProductFlag;
    logic             load_Initial;
    logic             addEnable;
    logic             shiftEnable;
    logic             negateEnable;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] stepCount;

    int  vectors;
    int  miscompares;
    expT sb[$];

    mult_sequence_controller #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .resultAck          (resultAck),
        .multiplierLsb      (multiplierLsb),
        .negativeProductFlag(negativeProductFlag),
        .load_Initial       (load_Initial),
        .addEnable          (addEnable),
        .shiftEnable        (shiftEnable),
        .negateEnable       (negateEnable),
        .busy               (busy),
        .done               (done),
        .stepCount          (stepCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // {load, add, shift, neg, busy, done, stepCount}
    function automatic logic [9:0] ex(input logic l, input logic a, input logic s,
                                      input logic n, input logic b, input logic d,
                                      input logic [3:0] c);
        return {l, a, s, n, b, d, c};
    endfunction

    task automatic pushExp(input logic [9:0] e, input logic [9:0] m);
        expT t;
        t.e = e;
        t.m = m;
        sb.push_back(t);
    endtask

    task automatic popCheck(input string tag);
        expT        t;
        logic [9:0] obs;
        obs = {load_Initial, addEnable, shiftEnable, negateEnable, busy, done, stepCount};
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            t = sb.pop_front();
            vectors++;
            assert ((obs & t.m) === (t.e & t.m))
            else begin
                miscompares++;
                $error("FAIL %s: observed %h required %h (mask %h)", tag, obs, t.e, t.m);
            end
        end
    endtask

    // Called just after a rising edge: drive this cycle's inputs, check at the falling edge,
    // then return just after the next rising edge.
    task automatic cyc(input logic st, input logic ack, input logic lsb, input logic npf,
                       input logic [9:0] e, input logic [9:0] m, input string tag);
        start               = st;
        resultAck           = ack;
        multiplierLsb       = lsb;
        negativeProductFlag = npf;
        pushExp(e, m);
        @(negedge clk);
        popCheck(tag);
        @(posedge clk);
        #1;
    endtask

    // Runs LOAD, the seven ITER cycles and SIGN; start must have been sampled in the prior cycle.
    task automatic runOp(input logic [6:0] pat, input logic npf, input logic pokeStart,
                         input string tag);
        cyc(1'b0, 1'b0, 1'b0, npf, ex(1, 0, 0, 0, 1, 0, 4'd0), Full, {tag, "_load"});
        for (int i = 0; i < 7; i++) begin
            cyc(pokeStart && (i == 3), 1'b0, pat[i], npf,
                ex(0, pat[i], 1, 0, 1, 0, 4'(i)), Full, $sformatf("%s_iter%0d", tag, i));
        end
        cyc(pokeStart, 1'b0, 1'b0, npf, ex(0, 0, 0, npf, 1, 0, 4'd7), Full, {tag, "_sign"});
    endtask

    localparam logic [6:0] PatA = 7'b1001101;
    localparam logic [6:0] PatB = 7'b0110010;

    initial begin
        vectors             = 0;
        miscompares         = 0;
        reset               = 1'b0;
        start               = 1'b1;
        resultAck           = 1'b0;
        multiplierLsb       = 1'b1;
        negativeProductFlag = 1'b1;

        // Asynchronous reset asserted between edges with start high.
        #2 reset = 1'b1;
        #1;
        pushExp(10'h000, Full);
        popCheck("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        pushExp(10'h000, Full);
        popCheck("reset_held");
        reset = 1'b0;

        // Nominal sequence, positive product.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), Full, "idle_after_reset");
        runOp(PatA, 1'b0, 1'b0, "nom");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "nom_done_hold");
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "nom_done_ack");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "nom_idle");

        // Negative product.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "neg_idle");
        runOp(PatA, 1'b1, 1'b0, "neg");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "neg_done");

        // start pulsed during ITER and SIGN is ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "ign_idle");
        runOp(PatA, 1'b0, 1'b1, "ign");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "ign_done");

        // Back-to-back: start with ack in DONE goes straight to LOAD.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "b2b_done");
        runOp(PatB, 1'b0, 1'b0, "b2b");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "b2b_done_ack");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "b2b_idle");

        // Abort mid-ITER (cycle 6), then a fresh operation.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "abort_idle");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 1, 0, 4'd0), Full, "abort_load");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, PatB[i], 1'b0, ex(0, PatB[i], 1, 0, 1, 0, 4'(i)), Full,
                $sformatf("abort_iter%0d", i));
        end
        multiplierLsb = 1'b1;
        #2 reset = 1'b1;
        #1;
        pushExp(10'h000, Full);
        popCheck("abort_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), Full, "abort_idle_a");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), Full, "abort_idle_b");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), Full, "restart_idle");
        runOp(PatA, 1'b1, 1'b0, "restart");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 1, 4'd7), Full, "restart_done");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 4'd0), NoCnt, "restart_idle_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
